// File: rtl/maxpool_stream_if.sv
// Input and output valid/ready streams of maxpool_stream.
// A beat transfers on a rising edge where valid and ready are both high; valid must not depend on ready.
interface maxpool_stream_if #(
  parameter int W = 45
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/maxpool_stream.sv
// 2x2 stride-2 max pooling over a raster-ordered stream with a half-row line buffer.
// Define POOL_ARGMAX_EN to add pool_argmax (winning position inside each window).
module maxpool_stream #(
  parameter int POOL_X          = 24,
  parameter int POOL_Y          = 24,
  parameter int POOL_DATA_WIDTH = 45
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pool_enable,
  maxpool_stream_if.slave      bus,
  output logic                 pool_done,
`ifdef POOL_ARGMAX_EN
  output logic [1:0]           pool_argmax,
`endif
  output logic [1:0]           fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW   = $clog2(POOL_X);
  localparam int RW   = $clog2(POOL_Y);
  localparam int LB_N = POOL_X / 2;
  localparam int LBW  = (LB_N > 1) ? $clog2(LB_N) : 1;
`ifdef POOL_ARGMAX_EN
  localparam int LBE  = POOL_DATA_WIDTH + 1;
`else
  localparam int LBE  = POOL_DATA_WIDTH;
`endif

  logic [1:0]                 state;
  logic [CW-1:0]              col;
  logic [RW-1:0]              row;
  logic [POOL_DATA_WIDTH-1:0] hreg;
  logic [POOL_DATA_WIDTH-1:0] od_q;
  logic                       ov_q;
  logic                       out_last;
  logic [LBE-1:0]             linebuf [LB_N];

  logic                       in_rdy;
  logic                       in_hs;
  logic                       out_hs;
  logic                       last_px;
  logic [LBW-1:0]             lb_idx;
  logic [LBE-1:0]             lb_rd;
  logic [LBE-1:0]             lb_wr;
  logic                       pair_sel;
  logic [POOL_DATA_WIDTH-1:0] pair_max;
  logic [POOL_DATA_WIDTH-1:0] top_max;
  logic                       bot_wins;
  logic [POOL_DATA_WIDTH-1:0] win_max;

  // Stalls even-row beats too whenever an output is waiting; keeps the ready path trivial.
  assign in_rdy  = (state == RUN) && (!ov_q || bus.out_ready);
  assign in_hs   = bus.in_valid && in_rdy;
  assign out_hs  = ov_q && bus.out_ready;
  assign last_px = (row == RW'(POOL_Y - 1)) && (col == CW'(POOL_X - 1));
  assign lb_idx  = LBW'(col >> 1);

  // Strict greater-than everywhere so the earlier raster position wins ties.
  assign pair_sel = bus.in_data > hreg;
  assign pair_max = pair_sel ? bus.in_data : hreg;
  assign lb_rd    = linebuf[lb_idx];
  assign top_max  = lb_rd[POOL_DATA_WIDTH-1:0];
  assign bot_wins = pair_max > top_max;
  assign win_max  = bot_wins ? pair_max : top_max;

`ifdef POOL_ARGMAX_EN
  logic       top_sel;
  logic [1:0] argmax_q;
  assign top_sel     = lb_rd[POOL_DATA_WIDTH];
  assign lb_wr       = {pair_sel, pair_max};
  assign pool_argmax = argmax_q;
`else
  assign lb_wr = pair_max;
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_data  = od_q;
  assign bus.out_valid = ov_q;
  assign pool_done     = (state == DONE);
  assign fsm_state     = state;

  always_ff @(posedge clk) begin
    if (in_hs && col[0] && !row[0]) begin
      linebuf[lb_idx] <= lb_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      hreg     <= '0;
      od_q     <= '0;
      ov_q     <= 1'b0;
      out_last <= 1'b0;
`ifdef POOL_ARGMAX_EN
      argmax_q <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pool_enable) begin
            state <= RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        RUN: begin
          if (!pool_enable) begin
            // Abort drops any pending output and skips the done pulse.
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            ov_q  <= 1'b0;
          end else begin
            if (in_hs) begin
              if (!col[0]) hreg <= bus.in_data;
              if (col == CW'(POOL_X - 1)) begin
                col <= '0;
                row <= (row == RW'(POOL_Y - 1)) ? '0 : row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
            if (in_hs && col[0] && row[0]) begin
              od_q     <= win_max;
              ov_q     <= 1'b1;
              out_last <= last_px;
`ifdef POOL_ARGMAX_EN
              argmax_q <= bot_wins ? {1'b1, pair_sel} : {1'b0, top_sel};
`endif
            end else if (out_hs) begin
              ov_q <= 1'b0;
            end
            if (out_hs && out_last) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream on a 4x4 frame: directed sequences, a window table and random frames
// checked against a frame-level pooling model.
`timescale 1ns/1ps
module tb_maxpool_stream;
  localparam int X    = 4;
  localparam int Y    = 4;
  localparam int W    = 45;
  localparam int NPIX = X * Y;
  localparam int NOUT = (X / 2) * (Y / 2);
  localparam logic [W-1:0] MAXV = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pool_enable = 1'b0;
  logic pool_done;
  logic [1:0] fsm_state;
  logic [1:0] argmax_w;

  always #5 clk = ~clk;

  maxpool_stream_if #(.W(W)) bus();

  maxpool_stream #(.POOL_X(X), .POOL_Y(Y), .POOL_DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pool_enable (pool_enable),
    .bus         (bus),
    .pool_done   (pool_done),
`ifdef POOL_ARGMAX_EN
    .pool_argmax (argmax_w),
`endif
    .fsm_state   (fsm_state)
  );
`ifndef POOL_ARGMAX_EN
  assign argmax_w = 2'd0;
`endif

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int neg_cnt = 0;
  int done_due = -1;
  int vis_due = -1;
  int acc_cnt = 0;
  int done_cnt = 0;
  int out_in_frame = 0;
  int mcount = 0;
  bit lat_en = 1'b0;
  logic [W-1:0] lat_exp;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] got_q[$];
  logic [W-1:0] pix[NPIX];
  logic [W-1:0] frame_px[NPIX];

  typedef struct packed {
    logic [W-1:0] p0, p1, p2, p3;
    logic [W-1:0] exp_max;
    logic [1:0]   exp_arg;
  } win_vec_t;
  win_vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // Frame-level model: store accepted pixels by raster index, pool each 2x2 window once complete.
  task automatic model_push(input logic [W-1:0] d);
    int n, r, c, best;
    logic [W-1:0] v[4];
    n = mcount;
    mcount++;
    if (n >= NPIX) return;
    pix[n] = d;
    r = n / X;
    c = n % X;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      v[0] = pix[n - X - 1];
      v[1] = pix[n - X];
      v[2] = pix[n - 1];
      v[3] = d;
      best = 0;
      for (int i = 1; i < 4; i++) if (v[i] > v[best]) best = i;
      exp_q.push_back({2'(best), v[best]});
      if (lat_en) begin
        vis_due = neg_cnt + 1;
        lat_exp = v[best];
      end
    end
  endtask

  task automatic model_reset();
    mcount = 0;
    out_in_frame = 0;
    acc_cnt = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- monitor / scoreboard (sampled on falling edge) ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    neg_cnt++;
    if (lat_en && neg_cnt == vis_due) begin
      check("latency_valid", 64'(bus.out_valid), 64'(1));
      check("latency_data", 64'(bus.out_data), 64'(lat_exp));
    end
    if (pool_done || neg_cnt == done_due)
      check("pool_done_pulse", 64'({pool_done, neg_cnt == done_due}), 64'(2'b11));
    if (pool_done) done_cnt++;
    if (bus.out_valid && bus.out_ready) begin
      got_q.push_back({argmax_w, bus.out_data});
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=0x%0h required=no_output", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 64'(bus.out_data), 64'(e[W-1:0]));
`ifdef POOL_ARGMAX_EN
        check("sb_argmax", 64'(argmax_w), 64'(e[W+1:W]));
`endif
      end
      out_in_frame++;
      if (out_in_frame == NOUT) done_due = neg_cnt + 1;
    end
    if (bus.in_valid && bus.in_ready) begin
      model_push(bus.in_data);
      acc_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    pool_enable = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic ramp_frame();
    for (int n = 0; n < NPIX; n++) frame_px[n] = W'(n);
  endtask

  task automatic send_frame(input int vpct, input int rpct, input bit keep_en);
    int start_done, cyc;
    start_done = done_cnt;
    cyc = 0;
    model_reset();
    pool_enable = 1'b1;
    while (done_cnt == start_done && cyc < 1000) begin
      if (acc_cnt < NPIX && int'($urandom_range(0, 99)) < vpct) begin
        bus.in_valid = 1'b1;
        bus.in_data = frame_px[acc_cnt];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data = rand_w();
      end
      bus.out_ready = (int'($urandom_range(0, 99)) < rpct);
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    if (!keep_en) pool_enable = 1'b0;
    check("frame_done_count", 64'(done_cnt - start_done), 64'(1));
    check("frame_inputs", 64'(acc_cnt), 64'(NPIX));
    check("frame_exp_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic expect_ramp_outputs(input string name);
    logic [W-1:0] want[4];
    want[0] = W'(5); want[1] = W'(7); want[2] = W'(13); want[3] = W'(15);
    check({name, "_count"}, 64'(got_q.size()), 64'(4));
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      check({name, "_value"}, 64'(got_q[k][W-1:0]), 64'(want[k]));
  endtask

  task automatic feed_six();
    int cyc;
    cyc = 0;
    model_reset();
    ramp_frame();
    pool_enable = 1'b1;
    bus.out_ready = 1'b0;
    while (acc_cnt < 6 && cyc < 50) begin
      bus.in_valid = 1'b1;
      bus.in_data = frame_px[acc_cnt];
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("six_beats_accepted", 64'(acc_cnt), 64'(6));
    check("six_beats_out_valid", 64'(bus.out_valid), 64'(1));
  endtask

  function automatic logic [W-1:0] pick(input win_vec_t v, input int idx);
    case (idx)
      0: return v.p0;
      1: return v.p1;
      2: return v.p2;
      default: return v.p3;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int cyc, start_done, d0;
    bit stalled;

    vecs[0] = '{p0: W'(1), p1: W'(9), p2: W'(3), p3: W'(2), exp_max: W'(9), exp_arg: 2'd1};
    vecs[1] = '{p0: W'(7), p1: W'(7), p2: W'(7), p3: W'(7), exp_max: W'(7), exp_arg: 2'd0};
    vecs[2] = '{p0: W'(0), p1: W'(0), p2: W'(0), p3: MAXV, exp_max: MAXV, exp_arg: 2'd3};
    vecs[3] = '{p0: W'(5), p1: W'(3), p2: W'(5), p3: W'(1), exp_max: W'(5), exp_arg: 2'd0};
    vecs[4] = '{p0: W'(2), p1: W'(4), p2: W'(8), p3: W'(8), exp_max: W'(8), exp_arg: 2'd2};
    vecs[5] = '{p0: MAXV, p1: MAXV - 1, p2: W'(0), p3: W'(0), exp_max: MAXV, exp_arg: 2'd0};
    vecs[6] = '{p0: W'(0), p1: W'(1), p2: W'(0), p3: W'(1), exp_max: W'(1), exp_arg: 2'd1};
    vecs[7] = '{p0: W'(10), p1: W'(20), p2: W'(30), p3: W'(25), exp_max: W'(30), exp_arg: 2'd2};

    do_reset();
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_out_data", 64'(bus.out_data), 64'(0));
    check("reset_in_ready", 64'(bus.in_ready), 64'(0));
    check("reset_pool_done", 64'(pool_done), 64'(0));
    check("reset_state", 64'(fsm_state), 64'(0));
`ifdef POOL_ARGMAX_EN
    check("reset_argmax", 64'(argmax_w), 64'(0));
`endif

    // Ramp frame with a free-flowing output: latency and done timing checked by the monitor.
    ramp_frame();
    lat_en = 1'b1;
    send_frame(100, 100, 1'b0);
    lat_en = 1'b0;
    expect_ramp_outputs("ramp");

    // Hold out_ready low for 5 cycles at the first output.
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    ramp_frame();
    pool_enable = 1'b1;
    bus.out_ready = 1'b1;
    stalled = 1'b0;
    cyc = 0;
    start_done = done_cnt;
    while (done_cnt == start_done && cyc < 200) begin
      if (bus.out_valid && !stalled) begin
        stalled = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = frame_px[acc_cnt];
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_out_data", 64'(bus.out_data), 64'(5));
          check("stall_out_valid", 64'(bus.out_valid), 64'(1));
          check("stall_in_ready", 64'(bus.in_ready), 64'(0));
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
      bus.in_valid = (acc_cnt < NPIX);
      bus.in_data = (acc_cnt < NPIX) ? frame_px[acc_cnt] : '0;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    pool_enable = 1'b0;
    check("stall_done", 64'(done_cnt - start_done), 64'(1));
    expect_ramp_outputs("stall");

    // Table-driven windows, four per frame.
    for (int g = 0; g < 2; g++) begin
      for (int n = 0; n < NPIX; n++)
        frame_px[n] = pick(vecs[g*4 + ((n / X) / 2) * 2 + (n % X) / 2], ((n / X) % 2) * 2 + (n % 2));
      send_frame(70, 60, 1'b0);
      check("table_count", 64'(got_q.size()), 64'(4));
      for (int k = 0; k < 4 && k < got_q.size(); k++) begin
        check("table_max", 64'(got_q[k][W-1:0]), 64'(vecs[g*4 + k].exp_max));
`ifdef POOL_ARGMAX_EN
        check("table_argmax", 64'(got_q[k][W+1:W]), 64'(vecs[g*4 + k].exp_arg));
`endif
      end
    end

    // Mid-frame abort with an output pending, then a fresh frame.
    d0 = done_cnt;
    feed_six();
    pool_enable = 1'b0;
    @(posedge clk);
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'(0));
    check("abort_state", 64'(fsm_state), 64'(0));
    check("abort_in_ready", 64'(bus.in_ready), 64'(0));
    model_reset();
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("abort_no_done", 64'(done_cnt - d0), 64'(0));
    ramp_frame();
    send_frame(100, 100, 1'b0);
    expect_ramp_outputs("after_abort");

    // Reset with an output pending.
    feed_six();
    rst = 1'b1;
    pool_enable = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_out_data", 64'(bus.out_data), 64'(0));
    check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
    check("midrst_pool_done", 64'(pool_done), 64'(0));
    rst = 1'b0;
    model_reset();

    // Random frames, the first ones back to back with pool_enable held high.
    for (int f = 0; f < 6; f++) begin
      for (int n = 0; n < NPIX; n++) begin
        case ($urandom_range(0, 3))
          0: frame_px[n] = W'($urandom_range(0, 3));
          1: frame_px[n] = MAXV;
          default: frame_px[n] = rand_w();
        endcase
      end
      send_frame(int'($urandom_range(40, 100)), int'($urandom_range(30, 100)), f < 5);
    end
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
- 2x2, stride-2 max-pooling stage directly downstream of the ReLU stage; one instance per feature-map channel.
- Consumes one ReLU result per accepted beat in raster order (row 0 col 0..POOL_X-1, then row 1, ...).
- Emits a (POOL_X/2)x(POOL_Y/2) pooled map in raster order over a valid/ready stream.
- Holds one line buffer of POOL_X/2 partial maxima.

Parameters:
- POOL_X, 24, input columns per row; must be even, >=2.
- POOL_Y, 24, input rows per frame; must be even, >=2.
- POOL_DATA_WIDTH, 45, data width; matches ReLU output width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- pool_enable  input  1  level; high starts/continues a frame; low aborts.
- in_data  input  POOL_DATA_WIDTH  ReLU result, non-negative, compared unsigned.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  POOL_DATA_WIDTH  pooled maximum.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- pool_done  output  1  one-cycle pulse after the last pooled value is accepted.

Behaviour:
- Reset: FSM=IDLE, col=0, row=0, out_data=0, out_valid=0, in_ready=0, pool_done=0; line buffer contents are don't-care.
- FSM IDLE: in_ready=0. Moves to RUN on the next edge when pool_enable=1, with col/row cleared.
- FSM RUN: in_ready = !out_valid | out_ready. An input handshake occurs when in_valid & in_ready.
- FSM RUN to DONE: on the output handshake of pooled element (POOL_X/2-1, POOL_Y/2-1).
- FSM DONE: pool_done=1 for exactly one cycle, then IDLE.
- FSM restart: if pool_enable is still high in IDLE, a new frame starts on the following edge.
- Per input handshake at (row, col):
  - Even col: hreg <= in_data.
  - Odd col, even row: linebuf[col/2] <= max(hreg, in_data).
  - Odd col, odd row: out_data <= max(linebuf[col/2], hreg, in_data); out_valid <= 1.
  - col increments; at POOL_X-1 it wraps to 0 and row increments. Row wraps are irrelevant because the frame ends.
- Latency: out_valid rises the cycle after the handshake of the bottom-right pixel of each 2x2 window.
- Output hold: out_valid stays high and out_data stays stable until out_valid & out_ready.
- Simultaneous output accept and new pooled result in the same cycle: the new value loads and out_valid stays 1 (no bubble).
- Back-pressure: in_ready drops only while out_valid=1 and out_ready=0. This is conservative: even-row beats are also stalled.
- Throughput: 1 input per cycle under continuous out_ready=1.
- pool_enable low in RUN (mid-frame abort): next edge FSM=IDLE, col=row=0, out_valid=0. A pending output is discarded and pool_done is not pulsed.
- Inputs presented while in IDLE or DONE are not accepted (in_ready=0).
- Comparisons are unsigned, full POOL_DATA_WIDTH; no truncation.
- Ties: the earliest raster position wins. This does not affect data, only the optional index output.

Optional Feature:
- Macro POOL_ARGMAX_EN.
- Defined: adds output pool_argmax [1:0] (index 0=top-left, 1=top-right, 2=bottom-left, 3=bottom-right of the window).
  - Registered alongside out_data and held with it.
  - Line buffer widens by 1 bit per entry; hreg carries no index.
  - Ties resolve to the lowest index. Reset value is 0.
- Undefined: port absent, line buffer POOL_DATA_WIDTH wide, behaviour otherwise identical.

Test Plan:
- 4x4 frame (POOL_X=POOL_Y=4), inputs 0..15 raster, out_ready=1 -> outputs 5,7,13,15, each 1 cycle after its window's last beat; pool_done pulses 1 cycle after the 4th accept.
- Same frame with out_ready=0 held 5 cycles at the first output -> out_data=5 stable, in_ready=0 those cycles, no input lost; final sequence still 5,7,13,15.
- All inputs = 7 with POOL_ARGMAX_EN -> every out_data=7, pool_argmax=0 (tie rule).
- Window {1,9,3,2} placed top-left, with POOL_ARGMAX_EN -> out_data=9, pool_argmax=1; max 2^45-1 in the bottom-right -> out_data=2^45-1, argmax=3.
- pool_enable dropped after 6 input beats, then raised again with a fresh 0..15 frame -> no pool_done for the aborted frame; new frame outputs 5,7,13,15.
- rst asserted mid-frame with out_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=0, pool_done=0.
